// File: rtl/nibble_ser_tx_if.sv
// rtl/nibble_ser_tx_if.sv - handshake and serial-line bundle for the nibble transmitter
interface nibble_ser_tx_if;
  logic [3:0] data_in;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;

  modport master (
    output data_in,
    output valid,
    input  ready,
    input  tx,
    input  busy
  );

  modport slave (
    input  data_in,
    input  valid,
    output ready,
    output tx,
    output busy
  );
endinterface

// File: rtl/nibble_ser_tx.sv
// rtl/nibble_ser_tx.sv - nibble serializer: start, 4 data bits LSB-first, optional even parity, stop
module nibble_ser_tx #(
  parameter int DIV       = 4,
  parameter int PARITY_EN = 0
) (
  input  logic            clk,
  input  logic            Rst,
  nibble_ser_tx_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state;
  logic [1:0] bit_cnt;
  logic [7:0] div_cnt;
  logic [3:0] shreg;
  logic       par;
  logic       bit_end;

  assign bit_end = (div_cnt == 8'(DIV - 1));

  // tx is loaded with the level of the state being entered, so it always comes straight from a flop
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      bus.tx    <= 1'b1;
      bus.ready <= 1'b1;
      bus.busy  <= 1'b0;
      bit_cnt   <= 2'd0;
      div_cnt   <= 8'd0;
      shreg     <= 4'd0;
      par       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid) begin
            shreg     <= bus.data_in;
            par       <= ^bus.data_in;
            state     <= START;
            bus.tx    <= 1'b0;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b1;
            div_cnt   <= 8'd0;
          end
        end
        START: begin
          if (bit_end) begin
            div_cnt <= 8'd0;
            bit_cnt <= 2'd0;
            state   <= DATA;
            bus.tx  <= shreg[0];
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= 8'd0;
            if (bit_cnt == 2'd3) begin
              if (PARITY_EN != 0) begin
                state  <= PARITY;
                bus.tx <= par;
              end else begin
                state  <= STOP;
                bus.tx <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 2'd1;
              bus.tx  <= shreg[bit_cnt + 2'd1];
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            div_cnt <= 8'd0;
            state   <= STOP;
            bus.tx  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            div_cnt   <= 8'd0;
            state     <= IDLE;
            bus.tx    <= 1'b1;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          bus.tx    <= 1'b1;
          bus.ready <= 1'b1;
          bus.busy  <= 1'b0;
          div_cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_ser_tx.sv
// tb/tb_nibble_ser_tx.sv - four transmitter configurations checked every cycle against a frame-queue model
module tb_nibble_ser_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       chk_on;
  logic [3:0] d_s     [4];
  logic       v_s     [4];
  logic       tx_w    [4];
  logic       ready_w [4];
  logic       busy_w  [4];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [31:0] cap;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Instances: 0 DIV=2 no parity, 1 DIV=1 parity, 2 DIV=4 no parity, 3 DIV=1 no parity
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D = (g == 0) ? 2 : (g == 2) ? 4 : 1;
    localparam int P = (g == 1) ? 1 : 0;

    nibble_ser_tx_if bus ();
    assign bus.data_in = d_s[g];
    assign bus.valid   = v_s[g];
    assign tx_w[g]     = bus.tx;
    assign ready_w[g]  = bus.ready;
    assign busy_w[g]   = bus.busy;

    nibble_ser_tx #(.DIV(D), .PARITY_EN(P)) dut (
      .clk (clk),
      .Rst (rst),
      .bus (bus)
    );

    bit         q[$];
    bit         fr[$];
    logic [3:0] dd;
    bit         e_tx   = 1'b1;
    bit         m_idle = 1'b1;

    // Model: a queue of upcoming line levels; a nibble is taken only when the previous cycle was idle
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete();
        e_tx   = 1'b1;
        m_idle = 1'b1;
      end else begin
        if (m_idle && v_s[g]) begin
          dd = d_s[g];
          fr.delete();
          fr.push_back(1'b0);
          for (int i = 0; i < 4; i++) fr.push_back(dd[i]);
          if (P != 0) fr.push_back(bit'($countones(dd) % 2));
          fr.push_back(1'b1);
          foreach (fr[i]) repeat (D) q.push_back(fr[i]);
        end
        if (q.size() > 0) begin
          e_tx   = q.pop_front();
          m_idle = 1'b0;
        end else begin
          e_tx   = 1'b1;
          m_idle = 1'b1;
        end
      end
    end

    always @(posedge clk) begin
      #3;
      if (!rst && chk_on) begin
        chk($sformatf("tx%0d", g),    32'(bus.tx),    32'(e_tx));
        chk($sformatf("ready%0d", g), 32'(bus.ready), 32'(m_idle));
        chk($sformatf("busy%0d", g),  32'(bus.busy),  32'(!m_idle));
      end
    end
  end

  task automatic pulse_rst(input string tag);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_tx"},    32'(tx_w[k]),    32'd1);
      chk({tag, "_ready"}, 32'(ready_w[k]), 32'd1);
      chk({tag, "_busy"},  32'(busy_w[k]),  32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic capture(input int k, input int n, output logic [31:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      bits[i] = tx_w[k];
      @(negedge clk);
    end
  endtask

  task automatic send(input int k, input logic [3:0] d);
    v_s[k] = 1'b1;
    d_s[k] = d;
    @(negedge clk);
    v_s[k] = 1'b0;
    d_s[k] = 4'($urandom);
  endtask

  initial begin
    rst    = 1'b1;
    chk_on = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v_s[k] = 1'b0;
      d_s[k] = 4'd0;
    end
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_on = 1'b1;

    pulse_rst("rst_idle");
    repeat (20) @(negedge clk);

    send(0, 4'b1011);
    capture(0, 12, cap);
    chk("frame_1011", cap, 32'h0000_0F3C);
    chk("ready_after_frame", 32'(ready_w[0]), 32'd1);

    send(1, 4'b0111);
    capture(1, 7, cap);
    chk("par_0111", cap, 32'(7'b1101110));
    send(1, 4'b0011);
    capture(1, 7, cap);
    chk("par_0011", cap, 32'(7'b1000110));

    send(0, 4'hA);
    repeat (4) @(negedge clk);
    send(0, 4'h5);
    repeat (16) @(negedge clk);
    chk("reject_idle", 32'(busy_w[0]), 32'd0);

    v_s[3] = 1'b1;
    d_s[3] = 4'h3;
    @(negedge clk);
    d_s[3] = 4'hC;
    capture(3, 13, cap);
    v_s[3] = 1'b0;
    chk("b2b_3_C", cap, 32'(13'b1110001100110));
    repeat (4) @(negedge clk);

    send(2, 4'hF);
    repeat (13) @(negedge clk);
    pulse_rst("rst_mid");
    send(2, 4'h0);
    capture(2, 24, cap);
    chk("after_rst_0", cap, 32'h00F0_0000);

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) pulse_rst("rst_rand");
      for (int k = 0; k < 4; k++) begin
        v_s[k] = ($urandom_range(0, 2) == 0);
        d_s[k] = 4'($urandom);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) v_s[k] = 1'b0;
    repeat (40) @(negedge clk);
    for (int k = 0; k < 4; k++) chk("final_idle", 32'(ready_w[k]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
